// File: rtl/rc4_key_search_ctrl_if.sv
// Handshake bundle between the RC4 key-search sequencer and the per-key
// phase engines (init, shuffle, decrypt) plus the search status outputs.
interface rc4_key_search_ctrl_if;
    logic        start;
    logic        abort;
    logic        init_done;
    logic        shuffle_done;
    logic        decrypt_done;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        sub_reset;
    logic        init_start;
    logic        shuffle_start;
    logic        decrypt_start;
    logic [23:0] secret_key;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [23:0] found_key;

    // Side that commands the search and hosts the phase engines
    modport master (
        output start, abort, init_done, shuffle_done, decrypt_done,
               char_valid, char_data,
        input  sub_reset, init_start, shuffle_start, decrypt_start,
               secret_key, busy, found, exhausted, found_key
    );

    // The sequencer itself
    modport slave (
        input  start, abort, init_done, shuffle_done, decrypt_done,
               char_valid, char_data,
        output sub_reset, init_start, shuffle_start, decrypt_start,
               secret_key, busy, found, exhausted, found_key
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: walks candidate keys from KEY_START
// to KEY_END, runs clear/init/shuffle/decrypt for each, screens decrypted
// bytes and stops on the first key whose whole message is printable.
module rc4_key_search_ctrl #(
    parameter int unsigned KEY_WIDTH = 22,
    parameter int unsigned KEY_START = 0,
    parameter int unsigned KEY_END   = (1 << 22) - 1,
    parameter int unsigned MSG_LEN   = 32
) (
    input logic                 CLOCK_50,
    input logic                 reset_n,
    rc4_key_search_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(MSG_LEN + 1);
    localparam logic [KEY_WIDTH-1:0] KEY_FIRST = KEY_WIDTH'(KEY_START);
    localparam logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(KEY_END);
    localparam logic [CW-1:0]        LAST_IDX  = CW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT,
        DEC_GO, DEC_WAIT, NEXT_KEY, FOUND, EXHAUSTED
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q;
    logic [23:0]          found_key_q;
    logic [CW-1:0]        byte_count;
    logic                 key_load, key_inc, cnt_clr, cnt_inc, hit;
    logic                 is_print;

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and datapath strobes; abort overrides everything
    always_comb begin
        state_d  = state_q;
        key_load = 1'b0;
        key_inc  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        hit      = 1'b0;
        is_print = (bus.char_data == 8'h20) ||
                   (bus.char_data >= 8'h61 && bus.char_data <= 8'h7A);
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, FOUND, EXHAUSTED: if (bus.start) begin
                    state_d  = CLEAR;
                    key_load = 1'b1;
                end
                CLEAR: begin
                    state_d = INIT_GO;
                    cnt_clr = 1'b1;
                end
                INIT_GO:   state_d = INIT_WAIT;
                INIT_WAIT: if (bus.init_done) state_d = SHUF_GO;
                SHUF_GO:   state_d = SHUF_WAIT;
                SHUF_WAIT: if (bus.shuffle_done) state_d = DEC_GO;
                DEC_GO:    state_d = DEC_WAIT;
                DEC_WAIT: begin
                    if (bus.char_valid) begin
                        if (!is_print) begin
                            state_d = NEXT_KEY;
                        end else if (byte_count == LAST_IDX) begin
                            state_d = FOUND;
                            hit     = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (bus.decrypt_done) begin
                        // decrypt ended before a full message: reject
                        state_d = NEXT_KEY;
                    end
                end
                NEXT_KEY: begin
                    if (key_q == KEY_LAST) begin
                        state_d = EXHAUSTED;
                    end else begin
                        state_d = CLEAR;
                        key_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Candidate key, matched key and accepted-byte counter
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_q       <= KEY_FIRST;
            found_key_q <= '0;
            byte_count  <= '0;
        end else begin
            if (key_load) begin
                key_q       <= KEY_FIRST;
                found_key_q <= '0;
            end else if (key_inc) begin
                key_q <= key_q + 1'b1;
            end
            if (hit) found_key_q <= 24'(key_q);
            if (cnt_clr)      byte_count <= '0;
            else if (cnt_inc) byte_count <= byte_count + 1'b1;
        end
    end

    assign bus.sub_reset     = (state_q == IDLE) || (state_q == CLEAR);
    assign bus.init_start    = (state_q == INIT_GO);
    assign bus.shuffle_start = (state_q == SHUF_GO);
    assign bus.decrypt_start = (state_q == DEC_GO);
    assign bus.busy          = (state_q != IDLE) && (state_q != FOUND) &&
                               (state_q != EXHAUSTED);
    assign bus.found         = (state_q == FOUND);
    assign bus.exhausted     = (state_q == EXHAUSTED);
    assign bus.secret_key    = 24'(key_q);
    assign bus.found_key     = found_key_q;
endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: behavioural phase engines feed planned
// per-key byte streams; a search-level model predicts the outcome.
module tb_rc4_key_search_ctrl;
    localparam int KW = 4;
    localparam int KS = 5;
    localparam int KE = 15;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rc4_key_search_ctrl_if ifc ();

    rc4_key_search_ctrl #(
        .KEY_WIDTH(KW), .KEY_START(KS), .KEY_END(KE), .MSG_LEN(ML)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    // per-key planned decrypt output
    logic [7:0] stream [16][40];
    int         slen [16];
    bit         dwl  [16];
    int         lat_init = 1, lat_shuf = 1, lat_dec = 1;

    // activity counters
    int n_clear = 0, n_init = 0, n_shuf = 0, n_dec = 0;

    function automatic bit printable(input logic [7:0] b);
        return b == 8'd32 || (b >= 8'd97 && b <= 8'd122);
    endfunction

    function automatic logic [7:0] rnd_print();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] rnd_bad();
        logic [7:0] b;
        do b = 8'($urandom); while (printable(b));
        return b;
    endfunction

    task automatic plan_good(input int k, input bit last_done);
        for (int i = 0; i < ML; i++) stream[k][i] = rnd_print();
        slen[k] = ML;
        dwl[k]  = last_done;
    endtask

    task automatic plan_bad(input int k, input logic [7:0] first);
        plan_good(k, 1'b0);
        stream[k][0] = first;
    endtask

    task automatic plan_short(input int k, input int n);
        plan_good(k, 1'b0);
        slen[k] = n;
    endtask

    // Search outcome from the plan: first key delivering ML printable bytes
    task automatic model(output int fk, output int tries, output bit ex);
        bit ok;
        ex = 1'b1; fk = 0; tries = 0;
        for (int k = KS; k <= KE; k++) begin
            tries++;
            ok = (slen[k] >= ML);
            for (int i = 0; i < ML; i++)
                if (ok && !printable(stream[k][i])) ok = 1'b0;
            if (ok) begin fk = k; ex = 1'b0; break; end
        end
    endtask

    // Phase engines and monitor, active on the falling edge
    int i_cnt, s_cnt, d_wait, d_idx, d_key;
    bit i_run, s_run, d_run;
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifc.sub_reset && ifc.busy) n_clear++;
            if (ifc.init_start)    n_init++;
            if (ifc.shuffle_start) n_shuf++;
            if (ifc.decrypt_start) n_dec++;
        end
        if (!reset_n || ifc.sub_reset) begin
            ifc.init_done = 0; ifc.shuffle_done = 0; ifc.decrypt_done = 0;
            ifc.char_valid = 0; ifc.char_data = 8'h00;
            i_run = 0; s_run = 0; d_run = 0;
        end else begin
            ifc.char_valid = 0;
            if (ifc.init_start) begin i_run = 1; i_cnt = lat_init; end
            else if (i_run) begin
                if (i_cnt <= 1) begin ifc.init_done = 1; i_run = 0; end
                else i_cnt--;
            end
            if (ifc.shuffle_start) begin s_run = 1; s_cnt = lat_shuf; end
            else if (s_run) begin
                if (s_cnt <= 1) begin ifc.shuffle_done = 1; s_run = 0; end
                else s_cnt--;
            end
            if (ifc.decrypt_start) begin
                d_run = 1; d_wait = lat_dec; d_idx = 0;
                d_key = int'(ifc.secret_key[3:0]);
            end else if (d_run) begin
                if (d_wait > 0) d_wait--;
                else if (d_idx < slen[d_key]) begin
                    ifc.char_valid = 1;
                    ifc.char_data  = stream[d_key][d_idx];
                    if (d_idx == slen[d_key] - 1 && dwl[d_key]) begin
                        ifc.decrypt_done = 1; d_run = 0;
                    end
                    d_idx++;
                end else begin
                    ifc.decrypt_done = 1; d_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_clear = 0; n_init = 0; n_shuf = 0; n_dec = 0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(ifc.found || ifc.exhausted) && n < budget) begin tick(); n++; end
        chk({tag, "_timeout"}, 32'(ifc.found || ifc.exhausted), 32'd1);
    endtask

    task automatic rnd_lat();
        lat_init = $urandom_range(1, 6);
        lat_shuf = $urandom_range(1, 6);
        lat_dec  = $urandom_range(1, 4);
    endtask

    // Run one planned search and compare against the model
    task automatic run_search(input string tag);
        int fk, tries; bit ex;
        model(fk, tries, ex);
        clr_counts();
        pulse_start();
        wait_end(tag, 20000);
        chk({tag, "_found"}, 32'(ifc.found), 32'(!ex));
        chk({tag, "_exhausted"}, 32'(ifc.exhausted), 32'(ex));
        chk({tag, "_found_key"}, ifc.found_key, 32'(fk));
        chk({tag, "_clears"}, 32'(n_clear), 32'(tries));
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        int n;
        ifc.start = 0; ifc.abort = 0;
        for (int k = 0; k < 16; k++) plan_good(k, 1'b0);

        // reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_sub_reset", 32'(ifc.sub_reset), 32'd1);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_key", ifc.secret_key, 32'(KS));
        chk("rst_found", 32'(ifc.found), 32'd0);
        chk("rst_exh", 32'(ifc.exhausted), 32'd0);
        chk("rst_found_key", ifc.found_key, 32'd0);
        chk("rst_starts", 32'(ifc.init_start | ifc.shuffle_start | ifc.decrypt_start), 32'd0);

        // immediate hit with long phase latencies
        lat_init = 256; lat_shuf = 768; lat_dec = 10;
        plan_good(KS, 1'b0);
        for (int i = 0; i < ML; i++) stream[KS][i] = 8'h61;
        run_search("hit");
        chk("hit_n_init", 32'(n_init), 32'd1);
        chk("hit_n_shuf", 32'(n_shuf), 32'd1);
        chk("hit_n_dec", 32'(n_dec), 32'd1);

        // early reject: first three keys fail on byte 0
        rnd_lat();
        for (int k = KS; k < KS + 3; k++) plan_bad(k, 8'h41);
        plan_good(KS + 3, 1'b0);
        for (int i = 0; i < ML; i++) stream[KS + 3][i] = 8'h20;
        run_search("reject");
        chk("reject_n_dec", 32'(n_dec), 32'd4);

        // exhaust the range with random non-printable first bytes
        rnd_lat();
        for (int k = KS; k <= KE; k++) plan_bad(k, rnd_bad());
        run_search("exhaust");
        chk("exhaust_key", ifc.secret_key, 32'(KE));
        repeat (3) tick();
        chk("exhaust_hold", ifc.secret_key, 32'(KE));

        // short message rejects; done with last byte still accepts
        rnd_lat();
        plan_short(KS, 10);
        plan_good(KS + 1, 1'b1);
        run_search("short");

        // random mix: bad byte at a random position, then a good key
        rnd_lat();
        for (int k = KS; k < KS + 3; k++) begin
            plan_good(k, 1'b0);
            stream[k][$urandom_range(0, ML - 1)] = rnd_bad();
        end
        plan_good(KS + 3, $urandom_range(0, 1) == 1);
        run_search("mix");

        // abort during shuffle wait at key 9
        lat_init = 2; lat_shuf = 40; lat_dec = 2;
        for (int k = KS; k < 9; k++) plan_bad(k, rnd_bad());
        plan_good(9, 1'b0);
        pulse_start();
        n = 0;
        while (!(ifc.shuffle_start && ifc.secret_key == 24'd9) && n < 2000) begin tick(); n++; end
        chk("abort_reach", 32'(ifc.shuffle_start && ifc.secret_key == 24'd9), 32'd1);
        repeat (3) tick();
        ifc.abort = 1'b1; tick(); ifc.abort = 1'b0;
        chk("abort_sub_reset", 32'(ifc.sub_reset), 32'd1);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_key", ifc.secret_key, 32'd9);
        chk("abort_found", 32'(ifc.found), 32'd0);
        clr_counts();
        pulse_start();
        chk("restart_key", ifc.secret_key, 32'(KS));
        chk("restart_busy", 32'(ifc.busy), 32'd1);
        wait_end("restart", 20000);
        chk("restart_found_key", ifc.found_key, 32'd9);

        // asynchronous reset while in decrypt wait
        lat_init = 1; lat_shuf = 1; lat_dec = 50;
        for (int k = KS; k <= KE; k++) plan_bad(k, rnd_bad());
        pulse_start();
        n = 0;
        while (!ifc.decrypt_start && n < 200) begin tick(); n++; end
        chk("dec_reach", 32'(ifc.decrypt_start), 32'd1);
        repeat (2) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_sub_reset", 32'(ifc.sub_reset), 32'd1);
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_key", ifc.secret_key, 32'(KS));
        chk("arst_found", 32'(ifc.found), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Sequencer for the brute-force RC4 key search. Owns the current candidate `secret_key` and drives the existing per-key phases in order for each key: S-memory reset, s[i]=i init, key-schedule shuffle, and PRGA decrypt. It screens each decrypted byte as it arrives, rejects a key on the first non-printable byte, and steps to the next key. It stops on the first key whose full message is printable, or when the key range is exhausted. It sits in the top level and replaces the fixed one-pass phase sequencing there.

## Interface
- `KEY_WIDTH`, default 22: searched key bits. `secret_key` is this value zero-extended to 24 bits.
- `KEY_START`, default 0: first candidate key.
- `KEY_END`, default 2^22-1: last candidate key, inclusive. Must be ≥ `KEY_START`.
- `MSG_LEN`, default 32: message length in bytes.

Ports:
- `CLOCK_50` in, 1: the single clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: begin a search from `KEY_START`. Honoured in IDLE, FOUND and EXHAUSTED only.
- `abort` in, 1: return to IDLE from any state.
- `init_done` in, 1: s[i]=i phase complete (level).
- `shuffle_done` in, 1: shuffle phase complete (level).
- `decrypt_done` in, 1: decrypt phase complete (level).
- `char_valid` in, 1: one-cycle strobe, `char_data` is valid.
- `char_data` in, 8: decrypted byte.
- `sub_reset` out, 1: active-high clear to the phase FSMs.
- `init_start` out, 1: one-cycle pulse to start the init phase.
- `shuffle_start` out, 1: one-cycle pulse to start the shuffle phase.
- `decrypt_start` out, 1: one-cycle pulse to start the decrypt phase.
- `secret_key` out, 24: current candidate key.
- `busy` out, 1: high while searching.
- `found` out, 1: sticky; a printable key was found.
- `exhausted` out, 1: sticky; the range ended with no match.
- `found_key` out, 24: the matching key.

## Operation
- States: IDLE, CLEAR, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, NEXT_KEY, FOUND, EXHAUSTED.
- Outputs are Moore, decoded from the state register:
  - `sub_reset`=1 in IDLE and CLEAR.
  - `init_start`, `shuffle_start`, `decrypt_start` are each 1 only in INIT_GO, SHUF_GO and DEC_GO respectively.
  - `busy`=1 in CLEAR through NEXT_KEY.
  - `found`=1 in FOUND; `exhausted`=1 in EXHAUSTED.
- Transitions:
  - IDLE, FOUND or EXHAUSTED with `start` → CLEAR. The key register loads `KEY_START`; `found_key` clears to 0.
  - CLEAR → INIT_GO. `byte_count` clears to 0.
  - INIT_GO → INIT_WAIT; INIT_WAIT with `init_done` → SHUF_GO.
  - SHUF_GO → SHUF_WAIT; SHUF_WAIT with `shuffle_done` → DEC_GO.
  - DEC_GO → DEC_WAIT.
  - DEC_WAIT, evaluated in priority order:
    1. `char_valid` with a non-printable byte → NEXT_KEY.
    2. `char_valid` with a printable byte and `byte_count`==`MSG_LEN`-1 → FOUND; `found_key` ← `secret_key`.
    3. `char_valid` with a printable byte otherwise → `byte_count`+1.
    4. `decrypt_done` without an accept above → NEXT_KEY (short message counts as a reject).
  - NEXT_KEY: if key==`KEY_END` → EXHAUSTED, key held. Otherwise key+1 → CLEAR.
  - `abort` in any state → IDLE; key and `found_key` are held.
- Printable byte: 8'h20, or 8'h61 through 8'h7A inclusive.
- `byte_count` is `$clog2(MSG_LEN+1)` bits.
- The key increments in `KEY_WIDTH` bits and never wraps; `KEY_END` terminates the search.
- Done inputs are ignored outside their own WAIT state. `char_valid` is ignored outside DEC_WAIT.

## Timing
- Reset values: state IDLE, `sub_reset`=1, `secret_key`={0,`KEY_START`}, `found_key`=0, all other outputs 0.
- Each start pulse is exactly 1 cycle, issued 1 cycle after the previous phase's done is sampled.
- `sub_reset` is high for exactly 1 cycle (CLEAR) between consecutive keys.
- Per-key overhead excluding phase latency is 5 cycles: CLEAR, 3 GO states, NEXT_KEY.
- Reject takes effect on the cycle after the offending `char_valid`. `secret_key` changes in NEXT_KEY and is stable from CLEAR through DEC_WAIT.
- `found` and `found_key` are valid together, the cycle after the `MSG_LEN`-th printable byte.
- Async reset mid-phase returns to IDLE immediately. `sub_reset`=1 clears the phase FSMs.

## Test plan
- Reset: assert `reset_n`=0 in DEC_WAIT → next sample shows IDLE, `sub_reset`=1, `busy`=0, `secret_key`=0, `found`=0.
- Immediate hit: `start`; phase models return done after 256, 768 and 10 cycles; feed 32×8'h61 → `found`=1, `found_key`=0, exactly one each of `init_start`, `shuffle_start`, `decrypt_start`.
- Early reject: keys 0–2 get first byte 8'h41, key 3 gets 32×8'h20 → `found_key`=3, `sub_reset` pulsed 3 times after the initial CLEAR.
- Exhaust: `KEY_START`=5, `KEY_END`=7, always-invalid first byte → `exhausted`=1, `secret_key`=7, no wrap to 0, `busy`=0.
- Short message: `decrypt_done` after 10 printable bytes → NEXT_KEY, key+1. Last printable byte and `decrypt_done` in the same cycle → FOUND.
- Abort: `abort` in SHUF_WAIT at key 9 → IDLE, `sub_reset`=1, `secret_key`=9. Then `start` → `secret_key`=`KEY_START`.
